phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Responder side of the controller-to-timer phase interface in the washer design.
- The control FSM requests a timed phase (fill, wash, drain, rinse, spin) with a one-cycle start pulse plus a phase code.
- This block times the phase, scaled by load size, and returns a one-cycle done flag on the matching line.
- It replaces free-running per-phase timers with a single handshaked, abortable down-counter.

Parameters:
- TICK_DIV, 50000000, clk cycles per timer tick (1 s at 50 MHz); minimum 1.
- CNT_W, 8, width of the remaining-tick counter.
- FILL_T, 10, fill base duration in ticks; scaled by load.
- WASH_T, 30, wash base duration in ticks; scaled by load.
- DRAIN_T, 8, drain duration in ticks; fixed.
- RINSE_T, 20, rinse base duration in ticks; scaled by load.
- SPIN_T, 15, spin duration in ticks; fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle phase request from the controller.
- abort  in  1  cancel the running phase (door opened).
- phase  in  3  phase code: 0 fill, 1 wash, 2 drain, 3 rinse, 4 spin; 5-7 illegal.
- load  in  2  load size 0..3; multiplier is load+1.
- tf  out  1  fill done, one-cycle pulse.
- tw  out  1  wash done, one-cycle pulse.
- td  out  1  drain done, one-cycle pulse.
- tr  out  1  rinse done, one-cycle pulse.
- ts  out  1  spin done, one-cycle pulse.
- busy  out  1  phase in progress.
- err  out  1  one-cycle pulse on illegal phase code.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- Reset: reset low asynchronously forces state IDLE. All outputs are 0, the prescaler is 0 and the latched phase is 0.
- States: IDLE, RUN.
- IDLE -> RUN when start=1 and the phase code is legal, sampled at edge k. At edge k:
  - remaining <= D and busy <= 1.
  - The prescaler and phase are latched.
- Duration D:
  - Fill, wash, rinse: D = BASE*(load+1).
  - Drain, spin: D = BASE.
  - load is sampled only at edge k; later load changes do not affect a running phase.
  - Any BASE of 0 is treated as 1.
  - D is computed at CNT_W+2 bits and saturates to 2^CNT_W-1.
- RUN:
  - The prescaler increments every cycle.
  - At TICK_DIV-1 the prescaler wraps to 0 and remaining decrements.
  - When remaining decrements 1 -> 0: return to IDLE, busy <= 0, and the latched phase's done flag <= 1 for exactly one cycle.
  - Done latency is exactly D*TICK_DIV cycles after edge k.
- Illegal phase code with start in IDLE: state stays IDLE, err pulses for one cycle, no done flag.
- start while in RUN: ignored. No restart, no err, and the latched phase and load are unchanged.
- abort=1 in RUN:
  - Next edge returns to IDLE.
  - busy <= 0, remaining <= 0, prescaler <= 0.
  - No done flag.
- abort has priority over a same-cycle final decrement: no done flag is issued.
- abort in IDLE: no effect.
- start and abort in the same cycle in IDLE: abort wins and start is ignored.
- Done flags are mutually exclusive; at most one is high in any cycle.
- Back-to-back operation: start in the cycle the done flag is high is accepted, because the state is already IDLE. The new phase begins at that edge.
- Reset mid-phase: immediate return to IDLE, no done flag; the next start times the full duration.

Test Plan:
- TICK_DIV=4, FILL_T=3, load=2, start with phase=0 at edge 0 -> D=9; tf high exactly at cycle 36 for one cycle; busy high during cycles 0-35; remaining 9..1 then 0.
- Drain (phase=2, DRAIN_T=8) with load=3 -> td at cycle 32; load ignored.
- Wash running, abort asserted at cycle 10 -> busy=0 at edge 11, no tw ever; a following start runs the full duration.
- start with phase=6 in IDLE -> err pulse for one cycle, busy stays 0, no done flags.
- Second start mid-rinse with phase=4 -> ignored; tr arrives at the original time, no ts.
- reset driven low asynchronously mid-spin -> outputs 0 immediately; after release, start with phase=4 gives ts after the full SPIN_T*TICK_DIV cycles.
- Base of 0 -> done after 1 tick.
- Large BASE with load=3 -> remaining saturates at 255 for CNT_W=8.

Source files
------------

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//
// Responder side of the controller-to-timer phase interface in the washer.
// The control FSM issues a one-cycle start pulse together with a phase code.
// This block times the phase as a number of ticks (scaled by load size for
// fill, wash and rinse), then returns a one-cycle done pulse on the line that
// matches the latched phase. A running phase can be aborted at any time.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle phase request
//   abort      in   cancel the running phase (door opened)
//   phase[2:0] in   0 fill, 1 wash, 2 drain, 3 rinse, 4 spin; 5-7 illegal
//   load[1:0]  in   load size 0..3, multiplier is load+1
//   tf/tw/td/tr/ts  out  fill/wash/drain/rinse/spin done, one-cycle pulses
//   busy       out  phase in progress
//   err        out  one-cycle pulse on a start with an illegal phase code
//   remaining  out  ticks left in the current phase
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8,
  parameter int FILL_T   = 10,
  parameter int WASH_T   = 30,
  parameter int DRAIN_T  = 8,
  parameter int RINSE_T  = 20,
  parameter int SPIN_T   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       phase,
  input  logic [1:0]       load,
  output logic             tf,
  output logic             tw,
  output logic             td,
  output logic             tr,
  output logic             ts,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] remaining
);

  // Prescaler counts 0..TICK_DIV-1; a divider of 1 still needs one bit.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  localparam int DUR_W   = CNT_W + 2;

  localparam logic [2:0] PH_FILL  = 3'd0;
  localparam logic [2:0] PH_WASH  = 3'd1;
  localparam logic [2:0] PH_DRAIN = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;

  // A base of 0 behaves as 1 tick. Bases are also capped at the counter
  // maximum so that base*(load+1) always fits in the CNT_W+2 bit product.
  function automatic logic [DUR_W-1:0] norm_base(input int base);
    if (base < 1)
      return DUR_W'(1);
    else if (base > MAX_CNT)
      return DUR_W'(MAX_CNT);
    else
      return DUR_W'(base);
  endfunction

  localparam logic [DUR_W-1:0] FILL_B  = norm_base(FILL_T);
  localparam logic [DUR_W-1:0] WASH_B  = norm_base(WASH_T);
  localparam logic [DUR_W-1:0] DRAIN_B = norm_base(DRAIN_T);
  localparam logic [DUR_W-1:0] RINSE_B = norm_base(RINSE_T);
  localparam logic [DUR_W-1:0] SPIN_B  = norm_base(SPIN_T);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_rem;
  logic [PRE_W-1:0]   r_pre;
  logic [2:0]         r_phase;
  logic [4:0]         r_done;
  logic               r_err;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_rem_nx;
  logic [PRE_W-1:0]   w_pre_nx;
  logic [2:0]         w_phase_nx;
  logic [4:0]         w_done_nx;
  logic               w_err_nx;

  logic [DUR_W-1:0]   w_base;
  logic               w_scaled_phase;
  logic [DUR_W-1:0]   w_mult;
  logic [DUR_W-1:0]   w_prod;
  logic [CNT_W-1:0]   w_dur;
  logic               w_legal;

  // Duration of the requested phase, evaluated from the live inputs so that
  // load is captured only on the accepting edge.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_base         = SPIN_B;
    w_scaled_phase = 1'b0;
    w_legal        = 1'b1;
    case (phase)
      PH_FILL:  begin w_base = FILL_B;  w_scaled_phase = 1'b1; end
      PH_WASH:  begin w_base = WASH_B;  w_scaled_phase = 1'b1; end
      PH_DRAIN: w_base = DRAIN_B;
      PH_RINSE: begin w_base = RINSE_B; w_scaled_phase = 1'b1; end
      PH_SPIN:  w_base = SPIN_B;
      default:  w_legal = 1'b0;
    endcase

    w_mult = DUR_W'({1'b0, load}) + DUR_W'(1);
    w_prod = w_scaled_phase ? (w_base * w_mult) : w_base;
    w_dur  = (w_prod > DUR_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : w_prod[CNT_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    w_pre_nx   = r_pre;
    w_phase_nx = r_phase;
    w_done_nx  = '0;
    w_err_nx   = 1'b0;

    case (r_state)
      IDLE: begin
        // abort outranks a same-cycle start even while idle.
        if (!abort && start) begin
          if (w_legal) begin
            w_state_nx = RUN;
            w_rem_nx   = w_dur;
            w_pre_nx   = '0;
            w_phase_nx = phase;
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // Abort also wins over a final decrement: no done pulse.
          w_state_nx = IDLE;
          w_rem_nx   = '0;
          w_pre_nx   = '0;
        end else if (r_pre == PRE_LAST) begin
          w_pre_nx = '0;
          w_rem_nx = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_nx = IDLE;
            w_done_nx  = 5'(5'd1 << r_phase);
          end
        end else begin
          w_pre_nx = r_pre + PRE_W'(1);
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_pre   <= '0;
      r_phase <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      r_state <= w_state_nx;
      r_rem   <= w_rem_nx;
      r_pre   <= w_pre_nx;
      r_phase <= w_phase_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  assign tf        = r_done[0];
  assign tw        = r_done[1];
  assign td        = r_done[2];
  assign tr        = r_done[3];
  assign ts        = r_done[4];
  assign busy      = (r_state == RUN);
  assign err       = r_err;
  assign remaining = r_rem;

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//
// Self-checking bench for phase_timer. The driver applies directed and random
// requests and, for every request, computes from the timing rules when and
// on which line a response (done or err pulse) must appear, queuing it. A
// separate monitor pops that queue whenever the DUT pulses a response line.
// busy and remaining are compared each cycle against the same reference
// model, which tracks only the accepting edge, duration and phase.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  localparam int T       = 4;
  localparam int CW      = 8;
  localparam int FILL_T  = 3;
  localparam int WASH_T  = 6;
  localparam int DRAIN_T = 0;
  localparam int RINSE_T = 100;
  localparam int SPIN_T  = 15;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    phase = 3'd0;
  logic [1:0]    load  = 2'd0;
  logic          tf, tw, td, tr, ts, busy, err;
  logic [CW-1:0] remaining;

  phase_timer #(
    .TICK_DIV (T),
    .CNT_W    (CW),
    .FILL_T   (FILL_T),
    .WASH_T   (WASH_T),
    .DRAIN_T  (DRAIN_T),
    .RINSE_T  (RINSE_T),
    .SPIN_T   (SPIN_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .phase     (phase),
    .load      (load),
    .tf        (tf),
    .tw        (tw),
    .td        (td),
    .tr        (tr),
    .ts        (ts),
    .busy      (busy),
    .err       (err),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; "cycle n" is the interval after edge n.
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Expected response: flags are {err, ts, tr, td, tw, tf}.
  typedef struct {
    logic [5:0] flags;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state.
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_d    = 0;
  int m_end  = 0;

  function automatic int dur(input int ph, input int ld);
    int base;
    int d;
    case (ph)
      0:       base = FILL_T;
      1:       base = WASH_T;
      2:       base = DRAIN_T;
      3:       base = RINSE_T;
      default: base = SPIN_T;
    endcase
    if (base == 0) base = 1;
    if (ph == 0 || ph == 1 || ph == 3) d = base * (ld + 1);
    else d = base;
    if (d > (1 << CW) - 1) d = (1 << CW) - 1;
    return d;
  endfunction

  task automatic model_retire();
    if (m_busy && m_end <= edge_n) m_busy = 1'b0;
  endtask

  task automatic check_state();
    int exp_rem;
    exp_rem = m_busy ? (m_d - (edge_n - m_k) / T) : 0;
    n_vec++;
    if (busy !== m_busy || remaining !== CW'(exp_rem)) begin
      n_bad++;
      $display("FAIL state cycle %0d: busy=%0b remaining=%0d, expected busy=%0b remaining=%0d",
               edge_n, busy, remaining, m_busy, exp_rem);
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({tf, tw, td, tr, ts, err, busy} !== 7'd0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL %s: flags=%b busy=%0b remaining=%0d, expected all zero",
               name, {err, ts, tr, td, tw, tf}, busy, remaining);
    end
  endtask

  // Inputs presented now are sampled at the coming edge, number edge_n+1.
  task automatic model_apply(input logic s, input logic a,
                             input logic [2:0] ph, input logic [1:0] ld);
    exp_t e;
    int   k;
    k = edge_n + 1;
    if (m_busy) begin
      if (a) begin
        void'(q.pop_back());
        m_busy = 1'b0;
      end
    end else if (!a && s) begin
      if (ph <= 3'd4) begin
        m_d    = dur(int'(ph), int'(ld));
        m_k    = k;
        m_end  = k + m_d * T;
        m_busy = 1'b1;
        e.flags = 6'(1 << int'(ph));
        e.cyc   = m_end;
        q.push_back(e);
      end else begin
        e.flags = 6'b100000;
        e.cyc   = k;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic s, input logic a,
                      input logic [2:0] ph, input logic [1:0] ld);
    @(negedge clk);
    model_retire();
    check_state();
    start = s;
    abort = a;
    phase = ph;
    load  = ld;
    model_apply(s, a, ph, ld);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
  endtask

  // Runs until the done edge of the current phase is the next edge, so the
  // caller's next step lands in the done cycle. Noisy mode adds ignored starts.
  task automatic wait_done(input bit noisy);
    while (m_busy && m_end > edge_n + 1) begin
      if (noisy)
        step($urandom_range(0, 5) == 0, 1'b0,
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      else
        idle_step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    model_retire();
    start = 1'b0;
    abort = 1'b0;
    #1;
    reset = 1'b0;
    if (m_busy) begin
      void'(q.pop_back());
      m_busy = 1'b0;
    end
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    logic [5:0] flags;
    exp_t       e;
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing_response: nothing seen, expected flags=%b at cycle %0d",
                 q[0].flags, q[0].cyc);
        void'(q.pop_front());
      end
      flags = {err, ts, tr, td, tw, tf};
      if (flags != 6'd0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: flags=%b at cycle %0d, expected none",
                   flags, edge_n);
        end else begin
          e = q.pop_front();
          if (e.flags !== flags || e.cyc != edge_n) begin
            n_bad++;
            $display("FAIL response: flags=%b at cycle %0d, expected flags=%b at cycle %0d",
                     flags, edge_n, e.flags, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_zero("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fill, load 2: D=9, done 36 cycles after the accepting edge;
    // extra starts while running must be ignored.
    step(1'b1, 1'b0, 3'd0, 2'd2);
    wait_done(1'b1);
    idle_step();

    // Drain with base 0 and load 3: one tick, load ignored.
    step(1'b1, 1'b0, 3'd2, 2'd3);
    wait_done(1'b0);
    idle_step();

    // Wash aborted ten cycles in, then a full wash.
    step(1'b1, 1'b0, 3'd1, 2'd1);
    repeat (9) idle_step();
    step(1'b0, 1'b1, 3'd0, 2'd0);
    repeat (2) idle_step();
    step(1'b1, 1'b0, 3'd1, 2'd1);
    wait_done(1'b0);
    idle_step();

    // Illegal codes, abort in idle, start+abort in idle.
    step(1'b1, 1'b0, 3'd6, 2'd0);
    idle_step();
    step(1'b1, 1'b0, 3'd7, 2'd2);
    step(1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b1, 1'b1, 3'd0, 2'd0);
    repeat (2) idle_step();

    // Rinse with a spin request in the middle that must be ignored.
    step(1'b1, 1'b0, 3'd3, 2'd0);
    repeat (30) idle_step();
    step(1'b1, 1'b0, 3'd4, 2'd0);
    wait_done(1'b0);
    idle_step();

    // Rinse load 3 saturates to 255 ticks; spin starts in the done cycle.
    step(1'b1, 1'b0, 3'd3, 2'd3);
    wait_done(1'b1);
    step(1'b1, 1'b0, 3'd4, 2'd2);

    // Reset mid-spin, then a full spin.
    repeat (20) idle_step();
    do_reset();
    step(1'b1, 1'b0, 3'd4, 2'd1);
    wait_done(1'b0);
    idle_step();

    // Abort on the edge of the final decrement: no done pulse.
    step(1'b1, 1'b0, 3'd0, 2'd0);
    while (m_end > edge_n + 2) idle_step();
    step(1'b0, 1'b1, 3'd0, 2'd0);
    repeat (2) idle_step();

    // Random traffic.
    repeat (600)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    wait_done(1'b0);
    repeat (4) idle_step();

    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d responses outstanding, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
